// File: rtl/alarm_pkg.sv
// Shared alarm definitions: state encodings, digit width and default timing
// constants, used by alarm-set, display and trigger blocks.
package alarm_pkg;

    localparam int DIGIT_W        = 4;
    localparam int SEC_W          = 9;
    localparam int TONE_DIV_DEF   = 25000;
    localparam int RING_SEC_DEF   = 60;
    localparam int SNOOZE_SEC_DEF = 300;
    localparam int MAX_SNOOZE_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_RING   = 3'd2,
        ST_SNOOZE = 3'd3,
        ST_DONE   = 3'd4
    } alarm_state_e;

    // Raw digit compare of HH:MM against the alarm setting; no BCD validation.
    function automatic logic time_match(input logic [4*DIGIT_W-1:0] t,
                                        input logic [4*DIGIT_W-1:0] a);
        return t == a;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Active-low push-button conditioner: two-flop synchroniser plus a one-cycle
// pulse on the synchronised high-to-low edge (one event per press, however long held).
module btn_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_n_i,
    output logic press_o
);

    logic sync1_q, sync2_q, prev_q;

    // Flops idle high so releasing reset never looks like a press.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign press_o = prev_q & ~sync2_q;

endmodule

// File: rtl/alarm_trigger.sv
// Alarm trigger: rings a beeping buzzer when HH:MM reaches the alarm setting,
// with stop, limited snooze and auto-stop after a ring timeout.
module alarm_trigger
    import alarm_pkg::*;
#(
    parameter int TONE_DIV   = TONE_DIV_DEF,
    parameter int RING_SEC   = RING_SEC_DEF,
    parameter int SNOOZE_SEC = SNOOZE_SEC_DEF,
    parameter int MAX_SNOOZE = MAX_SNOOZE_DEF
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               SEC_TICK,
    input  logic [DIGIT_W-1:0] T_H10,
    input  logic [DIGIT_W-1:0] T_H1,
    input  logic [DIGIT_W-1:0] T_M10,
    input  logic [DIGIT_W-1:0] T_M1,
    input  logic [DIGIT_W-1:0] A_H10,
    input  logic [DIGIT_W-1:0] A_H1,
    input  logic [DIGIT_W-1:0] A_M10,
    input  logic [DIGIT_W-1:0] A_M1,
    input  logic               ALARM_EN,
    input  logic               SET_MODE,
    input  logic               BT_STOP,
    input  logic               BT_SNOOZE,
    output logic               BUZZER,
    output logic               RINGING,
    output logic               SNOOZING,
    output logic [2:0]         SNOOZE_CNT
);

    localparam int               DIV_W       = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(TONE_DIV - 1);
    localparam logic [SEC_W-1:0] RING_LAST   = SEC_W'(RING_SEC - 1);
    localparam logic [SEC_W-1:0] SNOOZE_LAST = SEC_W'(SNOOZE_SEC - 1);
    localparam logic [2:0]       SNOOZE_MAX  = 3'(MAX_SNOOZE);

    alarm_state_e     state_q, state_d;
    logic             match_q;
    logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
    logic [2:0]       snooze_cnt_q, snooze_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tone_q, tone_d;
    logic             beep_q, beep_d;
    logic             buzzer_q, buzzer_d;
    logic             ringing_q, snoozing_q;

    logic match_w, hit_w, disable_w, stop_w, snooze_w;

    btn_edge u_stop (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .btn_n_i (BT_STOP),
        .press_o (stop_w)
    );

    btn_edge u_snooze (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .btn_n_i (BT_SNOOZE),
        .press_o (snooze_w)
    );

    assign match_w   = time_match({T_H10, T_H1, T_M10, T_M1}, {A_H10, A_H1, A_M10, A_M1});
    // Only a fresh match rings; enabling onto an existing match stays silent.
    assign hit_w     = match_w & ~match_q;
    assign disable_w = ~ALARM_EN | SET_MODE;

    always_comb begin
        state_d      = state_q;
        snooze_cnt_d = snooze_cnt_q;
        if (state_q != ST_IDLE && disable_w) begin
            state_d      = ST_IDLE;
            snooze_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ALARM_EN && !SET_MODE) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (hit_w) begin
                        state_d      = ST_RING;
                        snooze_cnt_d = '0;
                    end
                end
                ST_RING: begin
                    if (stop_w) begin
                        state_d = ST_DONE;
                    end else if (snooze_w) begin
                        if (snooze_cnt_q < SNOOZE_MAX) begin
                            state_d      = ST_SNOOZE;
                            snooze_cnt_d = snooze_cnt_q + 3'd1;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else if (SEC_TICK && sec_cnt_q == RING_LAST) begin
                        state_d = ST_DONE;
                    end
                end
                ST_SNOOZE: begin
                    if (stop_w) begin
                        state_d = ST_DONE;
                    end else if (SEC_TICK && sec_cnt_q == SNOOZE_LAST) begin
                        state_d = ST_RING;
                    end
                end
                // Hold here until the minute moves on so the same match cannot re-trigger.
                ST_DONE: begin
                    if (!match_w) state_d = ST_ARMED;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        sec_cnt_d = sec_cnt_q;
        div_d     = '0;
        tone_d    = 1'b0;
        beep_d    = beep_q;
        if (state_d != state_q) begin
            sec_cnt_d = '0;
        end else if (SEC_TICK && (state_q == ST_RING || state_q == ST_SNOOZE)) begin
            sec_cnt_d = sec_cnt_q + 1'b1;
        end
        if (state_d == ST_RING && state_q == ST_RING) begin
            if (div_q == DIV_LAST) begin
                tone_d = ~tone_q;
            end else begin
                div_d  = div_q + 1'b1;
                tone_d = tone_q;
            end
            if (SEC_TICK) beep_d = ~beep_q;
        end else if (state_d == ST_RING) begin
            beep_d = 1'b1;
        end
        buzzer_d = tone_d & beep_d & (state_d == ST_RING);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            match_q      <= 1'b0;
            sec_cnt_q    <= '0;
            snooze_cnt_q <= '0;
            div_q        <= '0;
            tone_q       <= 1'b0;
            beep_q       <= 1'b0;
            buzzer_q     <= 1'b0;
            ringing_q    <= 1'b0;
            snoozing_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            match_q      <= match_w;
            sec_cnt_q    <= sec_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            div_q        <= div_d;
            tone_q       <= tone_d;
            beep_q       <= beep_d;
            buzzer_q     <= buzzer_d;
            ringing_q    <= (state_d == ST_RING);
            snoozing_q   <= (state_d == ST_SNOOZE);
        end
    end

    assign BUZZER     = buzzer_q;
    assign RINGING    = ringing_q;
    assign SNOOZING   = snoozing_q;
    assign SNOOZE_CNT = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// Bench for alarm_trigger: directed scenarios, a cycle-level behavioural model
// compared every negedge, plus hand-computed literal checks.
module tb_alarm_trigger;

    localparam int TD = 4;
    localparam int RS = 5;
    localparam int SS = 3;
    localparam int MS = 2;

    localparam int M_IDLE = 0, M_ARMED = 1, M_RING = 2, M_SNOOZE = 3, M_DONE = 4;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    logic SEC_TICK = 1'b0;
    logic [3:0] T_H10, T_H1, T_M10, T_M1;
    logic [3:0] A_H10, A_H1, A_M10, A_M1;
    logic ALARM_EN = 1'b0, SET_MODE = 1'b0, BT_STOP = 1'b1, BT_SNOOZE = 1'b1;
    logic BUZZER, RINGING, SNOOZING;
    logic [2:0] SNOOZE_CNT;

    int n_chk = 0, n_pass = 0;
    bit chk_en = 1'b0;

    // Model state: mode, seconds in current ring/snooze, snoozes used,
    // cycles since ring entry, seconds ticked while ringing, button history.
    int m_mode, m_secs, m_snz, m_k, m_rt;
    bit m_prev_match;
    bit [2:0] st_h, sn_h;

    alarm_trigger #(.TONE_DIV(TD), .RING_SEC(RS), .SNOOZE_SEC(SS), .MAX_SNOOZE(MS)) dut (
        .CLK(CLK), .RESET(RESET), .SEC_TICK(SEC_TICK),
        .T_H10(T_H10), .T_H1(T_H1), .T_M10(T_M10), .T_M1(T_M1),
        .A_H10(A_H10), .A_H1(A_H1), .A_M10(A_M10), .A_M1(A_M1),
        .ALARM_EN(ALARM_EN), .SET_MODE(SET_MODE), .BT_STOP(BT_STOP), .BT_SNOOZE(BT_SNOOZE),
        .BUZZER(BUZZER), .RINGING(RINGING), .SNOOZING(SNOOZING), .SNOOZE_CNT(SNOOZE_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_secs = 0; m_snz = 0; m_k = 0; m_rt = 0;
        m_prev_match = 1'b0;
        st_h = 3'b111; sn_h = 3'b111;
    endtask

    task automatic start_ring();
        m_mode = M_RING; m_secs = 0; m_k = 0; m_rt = 0;
    endtask

    function automatic int tval();
        return ((int'(T_H10) * 16 + int'(T_H1)) * 16 + int'(T_M10)) * 16 + int'(T_M1);
    endfunction

    function automatic int aval();
        return ((int'(A_H10) * 16 + int'(A_H1)) * 16 + int'(A_M10)) * 16 + int'(A_M1);
    endfunction

    // One clock edge worth of alarm behaviour, from inputs sampled at the edge.
    task automatic model_step();
        bit match, hit, st_ev, sn_ev, dis;
        if (RESET) begin model_reset(); return; end
        match = (tval() == aval());
        hit   = match && !m_prev_match;
        st_ev = st_h[2] && !st_h[1];
        sn_ev = sn_h[2] && !sn_h[1];
        dis   = !ALARM_EN || SET_MODE;
        if (m_mode != M_IDLE && dis) begin
            m_mode = M_IDLE; m_snz = 0;
        end else begin
            case (m_mode)
                M_IDLE:  if (ALARM_EN && !SET_MODE) m_mode = M_ARMED;
                M_ARMED: if (hit) begin start_ring(); m_snz = 0; end
                M_RING: begin
                    if (st_ev) m_mode = M_DONE;
                    else if (sn_ev) begin
                        if (m_snz < MS) begin m_snz++; m_mode = M_SNOOZE; m_secs = 0; end
                        else m_mode = M_DONE;
                    end else if (SEC_TICK && m_secs == RS - 1) m_mode = M_DONE;
                    else begin
                        m_k++;
                        if (SEC_TICK) begin m_secs++; m_rt++; end
                    end
                end
                M_SNOOZE: begin
                    if (st_ev) m_mode = M_DONE;
                    else if (SEC_TICK) begin
                        if (m_secs == SS - 1) start_ring();
                        else m_secs++;
                    end
                end
                M_DONE:  if (!match) m_mode = M_ARMED;
                default: ;
            endcase
        end
        m_prev_match = match;
        st_h = {st_h[1], st_h[0], BT_STOP};
        sn_h = {sn_h[1], sn_h[0], BT_SNOOZE};
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            cmp("model RINGING", 8'(RINGING), 8'(m_mode == M_RING));
            cmp("model SNOOZING", 8'(SNOOZING), 8'(m_mode == M_SNOOZE));
            cmp("model SNOOZE_CNT", 8'(SNOOZE_CNT), 8'(m_snz));
            cmp("model BUZZER", 8'(BUZZER),
                8'((m_mode == M_RING) && ((m_k / TD) % 2 == 1) && (m_rt % 2 == 0)));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            model_step();
            #1;
        end
    endtask

    task automatic sec();
        SEC_TICK = 1'b1; tick(1);
        SEC_TICK = 1'b0; tick(1);
    endtask

    task automatic set_t(input int h, input int m);
        T_H10 = 4'(h / 10); T_H1 = 4'(h % 10);
        T_M10 = 4'(m / 10); T_M1 = 4'(m % 10);
    endtask

    task automatic snooze_press();
        BT_SNOOZE = 1'b0; tick(4);
        BT_SNOOZE = 1'b1; tick(3);
    endtask

    initial begin
        A_H10 = 4'd0; A_H1 = 4'd7; A_M10 = 4'd3; A_M1 = 4'd0;
        set_t(7, 29);
        #1 RESET = 1'b1;
        model_reset();
        chk_en = 1'b1;
        tick(2);
        cmp("reset BUZZER", 8'(BUZZER), 8'd0);
        cmp("reset RINGING", 8'(RINGING), 8'd0);
        cmp("reset SNOOZING", 8'(SNOOZING), 8'd0);
        cmp("reset SNOOZE_CNT", 8'(SNOOZE_CNT), 8'd0);
        RESET = 1'b0;
        tick(1);

        // 1: ring on match, tone/beep gating, auto-stop after RS seconds
        ALARM_EN = 1'b1; tick(2);
        set_t(7, 30); tick(1);
        cmp("t1 ring start", 8'(RINGING), 8'd1);
        tick(3);
        cmp("t1 tone low phase", 8'(BUZZER), 8'd0);
        tick(1);
        cmp("t1 tone high phase", 8'(BUZZER), 8'd1);
        SEC_TICK = 1'b1; tick(1); SEC_TICK = 1'b0;
        cmp("t1 beep off after tick", 8'(BUZZER), 8'd0);
        tick(2);
        repeat (3) sec();
        cmp("t1 still ringing after 4 s", 8'(RINGING), 8'd1);
        sec();
        cmp("t1 auto-stop after 5 s", 8'(RINGING), 8'd0);
        set_t(7, 31); tick(2);

        // 2: stop button, latency 3, no re-ring while minute matches
        set_t(7, 30); tick(1);
        cmp("t2 ring start", 8'(RINGING), 8'd1);
        tick(3);
        BT_STOP = 1'b0; tick(2);
        cmp("t2 ringing 2 clk after stop", 8'(RINGING), 8'd1);
        tick(1);
        cmp("t2 stopped 3 clk after stop", 8'(RINGING), 8'd0);
        cmp("t2 buzzer silent", 8'(BUZZER), 8'd0);
        tick(7); BT_STOP = 1'b1;
        tick(20);
        cmp("t2 no re-ring", 8'(RINGING), 8'd0);
        set_t(7, 29); tick(1);

        // 3: snooze cycle up to limit
        set_t(7, 30); tick(1);
        cmp("t3 ring start", 8'(RINGING), 8'd1);
        BT_SNOOZE = 1'b0; tick(3);
        cmp("t3 snoozing", 8'(SNOOZING), 8'd1);
        cmp("t3 cnt 1", 8'(SNOOZE_CNT), 8'd1);
        tick(2); BT_SNOOZE = 1'b1; tick(3);
        snooze_press();
        cmp("t3 snooze ignored while snoozing", 8'(SNOOZE_CNT), 8'd1);
        repeat (3) sec();
        cmp("t3 re-ring after snooze", 8'(RINGING), 8'd1);
        BT_SNOOZE = 1'b0; tick(3);
        cmp("t3 cnt 2", 8'(SNOOZE_CNT), 8'd2);
        tick(2); BT_SNOOZE = 1'b1; tick(3);
        repeat (3) sec();
        cmp("t3 re-ring 2", 8'(RINGING), 8'd1);
        BT_SNOOZE = 1'b0; tick(3);
        cmp("t3 limit -> done ringing", 8'(RINGING), 8'd0);
        cmp("t3 limit -> done snoozing", 8'(SNOOZING), 8'd0);
        cmp("t3 cnt stays 2", 8'(SNOOZE_CNT), 8'd2);
        tick(2); BT_SNOOZE = 1'b1; tick(3);
        set_t(7, 31); tick(1);

        // 4: stop and snooze together -> stop wins
        set_t(7, 30); tick(1);
        cmp("t4 ring start", 8'(RINGING), 8'd1);
        cmp("t4 cnt cleared on ring", 8'(SNOOZE_CNT), 8'd0);
        snooze_press();
        repeat (3) sec();
        BT_STOP = 1'b0; BT_SNOOZE = 1'b0; tick(3);
        cmp("t4 both -> not ringing", 8'(RINGING), 8'd0);
        cmp("t4 both -> not snoozing", 8'(SNOOZING), 8'd0);
        cmp("t4 cnt unchanged", 8'(SNOOZE_CNT), 8'd1);
        tick(2); BT_STOP = 1'b1; BT_SNOOZE = 1'b1; tick(3);
        set_t(7, 31); tick(1);

        // 5: enable onto existing match, SET_MODE aborts ring
        ALARM_EN = 1'b0; tick(2);
        set_t(7, 30); tick(2);
        ALARM_EN = 1'b1; tick(6);
        cmp("t5 enable on match no ring", 8'(RINGING), 8'd0);
        set_t(7, 31); tick(1);
        set_t(7, 30); tick(1);
        cmp("t5 ring start", 8'(RINGING), 8'd1);
        snooze_press();
        repeat (3) sec();
        tick(3);
        cmp("t5 buzzer on before set", 8'(BUZZER), 8'd1);
        SET_MODE = 1'b1; tick(1);
        cmp("t5 set -> not ringing", 8'(RINGING), 8'd0);
        cmp("t5 set -> buzzer off", 8'(BUZZER), 8'd0);
        cmp("t5 set -> cnt cleared", 8'(SNOOZE_CNT), 8'd0);
        SET_MODE = 1'b0; tick(4);
        cmp("t5 re-arm on match no ring", 8'(RINGING), 8'd0);

        // 6: asynchronous reset mid-ring
        set_t(7, 31); tick(1);
        set_t(7, 30); tick(1);
        cmp("t6 ring start", 8'(RINGING), 8'd1);
        tick(4);
        #2 RESET = 1'b1;
        #1;
        cmp("t6 async BUZZER", 8'(BUZZER), 8'd0);
        cmp("t6 async RINGING", 8'(RINGING), 8'd0);
        cmp("t6 async SNOOZING", 8'(SNOOZING), 8'd0);
        cmp("t6 async SNOOZE_CNT", 8'(SNOOZE_CNT), 8'd0);
        model_reset();
        tick(2);
        RESET = 1'b0;
        tick(10);
        cmp("t6 persisting match silent", 8'(RINGING), 8'd0);
        set_t(7, 31); tick(1);
        set_t(7, 30); tick(1);
        cmp("t6 next match rings", 8'(RINGING), 8'd1);
        tick(2);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
